// File: rtl/pll_ctrl_pkg.sv
// Shared types and constants for the rPLL bring-up / reconfiguration controller.
package pll_ctrl_pkg;

  localparam int IDSEL_W  = 6;
  localparam int FBDSEL_W = 6;
  localparam int ODSEL_W  = 6;
  localparam int PSDA_W   = 4;

  // Divider codes for the Costas system clock (PLL native encoding).
  localparam logic [IDSEL_W-1:0]  COSTAS_IDSEL  = 6'd0;
  localparam logic [FBDSEL_W-1:0] COSTAS_FBDSEL = 6'd0;
  localparam logic [ODSEL_W-1:0]  COSTAS_ODSEL  = 6'd0;
  localparam logic [PSDA_W-1:0]   COSTAS_PSDA   = 4'd0;

  typedef enum logic [2:0] {S_PRST, S_WAIT, S_STABLE, S_RUN, S_FAULT} state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for signals asynchronous to clk; resets to 0.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reconfig_ctrl.sv
// rPLL sequencer: reset -> wait-for-lock -> stability qualify -> run, with retry,
// fault handling and divider reconfiguration; releases sys_rst_n once qualified.
module pll_reconfig_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int                   RST_HOLD_CYC     = 16,
  parameter int                   LOCK_TIMEOUT_CYC = 100000,
  parameter int                   LOCK_STABLE_CYC  = 1024,
  parameter int                   MAX_RETRY        = 3,
  parameter logic [IDSEL_W-1:0]   IDSEL_DEF        = COSTAS_IDSEL,
  parameter logic [FBDSEL_W-1:0]  FBDSEL_DEF       = COSTAS_FBDSEL,
  parameter logic [ODSEL_W-1:0]   ODSEL_DEF        = COSTAS_ODSEL,
  parameter logic [PSDA_W-1:0]    PSDA_DEF         = COSTAS_PSDA
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [IDSEL_W-1:0]   cfg_idsel,
  input  logic [FBDSEL_W-1:0]  cfg_fbdsel,
  input  logic [ODSEL_W-1:0]   cfg_odsel,
  input  logic [PSDA_W-1:0]    cfg_psda,
  input  logic                 pll_lock,
  output logic                 pll_reset,
  output logic [IDSEL_W-1:0]   pll_idsel,
  output logic [FBDSEL_W-1:0]  pll_fbdsel,
  output logic [ODSEL_W-1:0]   pll_odsel,
  output logic [PSDA_W-1:0]    pll_psda,
  output logic                 sys_rst_n,
  output logic                 locked,
  output logic                 fault,
  output logic                 lock_lost
);

  localparam int CNT_MAX = max3(RST_HOLD_CYC, LOCK_TIMEOUT_CYC, LOCK_STABLE_CYC);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int RTY_W   = $clog2(MAX_RETRY + 1);

  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [RTY_W-1:0] RTY_LIM  = RTY_W'(MAX_RETRY);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic [RTY_W-1:0] retry, retry_nxt, retry_inc;
  logic             lost_nxt;
  logic             lock_s;
  logic             hs;

  sync_2ff #(.W(1)) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  assign hs        = cfg_valid && cfg_ready;
  assign cnt_inc   = (cnt == CNT_SAT) ? cnt : cnt + 1'b1;
  assign retry_inc = retry + 1'b1;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    retry_nxt = retry;
    lost_nxt  = lock_lost;
    case (state)
      S_PRST: begin
        if (cnt >= RST_LAST) begin
          state_nxt = S_WAIT;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      S_WAIT: begin
        if (lock_s) begin
          // The synced-lock cycle seen here is the first of the stable run.
          if (LOCK_STABLE_CYC <= 1) begin
            state_nxt = S_RUN;
            retry_nxt = '0;
            cnt_nxt   = '0;
          end else begin
            state_nxt = S_STABLE;
            cnt_nxt   = CNT_W'(1);
          end
        end else if (cnt >= TO_LAST) begin
          retry_nxt = retry_inc;
          cnt_nxt   = '0;
          state_nxt = (retry_inc == RTY_LIM) ? S_FAULT : S_PRST;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      S_STABLE: begin
        if (!lock_s) begin
          state_nxt = S_WAIT;
          cnt_nxt   = '0;
        end else if (cnt >= STB_LAST) begin
          state_nxt = S_RUN;
          cnt_nxt   = '0;
          retry_nxt = '0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      S_RUN: begin
        if (!lock_s) begin
          state_nxt = S_PRST;
          cnt_nxt   = '0;
          lost_nxt  = 1'b1;
        end
      end
      S_FAULT: ;
      default: begin
        state_nxt = S_PRST;
        cnt_nxt   = '0;
      end
    endcase
    // A config handshake overrides everything, including a same-cycle lock drop.
    if (hs) begin
      state_nxt = S_PRST;
      cnt_nxt   = '0;
      retry_nxt = '0;
      lost_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_PRST;
      cnt   <= '0;
      retry <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      retry <= retry_nxt;
    end
  end

  // Outputs are registered from the next state so they track the state register exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pll_reset  <= 1'b1;
      sys_rst_n  <= 1'b0;
      locked     <= 1'b0;
      fault      <= 1'b0;
      cfg_ready  <= 1'b0;
      lock_lost  <= 1'b0;
      pll_idsel  <= IDSEL_DEF;
      pll_fbdsel <= FBDSEL_DEF;
      pll_odsel  <= ODSEL_DEF;
      pll_psda   <= PSDA_DEF;
    end else begin
      pll_reset <= (state_nxt == S_PRST) || (state_nxt == S_FAULT);
      sys_rst_n <= (state_nxt == S_RUN);
      locked    <= (state_nxt == S_RUN);
      fault     <= (state_nxt == S_FAULT);
      cfg_ready <= (state_nxt == S_RUN) || (state_nxt == S_FAULT);
      lock_lost <= lost_nxt;
      if (hs) begin
        pll_idsel  <= cfg_idsel;
        pll_fbdsel <= cfg_fbdsel;
        pll_odsel  <= cfg_odsel;
        pll_psda   <= cfg_psda;
      end
    end
  end

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Self-checking bench for pll_reconfig_ctrl: per-cycle vector tables plus hand sequences.
module tb_pll_reconfig_ctrl;

  localparam logic [5:0] ID_D = 6'h05;
  localparam logic [5:0] FB_D = 6'h0A;
  localparam logic [5:0] OD_D = 6'h11;
  localparam logic [3:0] PS_D = 4'h3;

  logic       clk, rst_n, cfg_valid, cfg_ready, pll_lock, pll_reset;
  logic       sys_rst_n, locked, fault, lock_lost;
  logic [5:0] cfg_idsel, cfg_fbdsel, cfg_odsel, pll_idsel, pll_fbdsel, pll_odsel;
  logic [3:0] cfg_psda, pll_psda;

  pll_reconfig_ctrl #(
    .RST_HOLD_CYC(4), .LOCK_TIMEOUT_CYC(20), .LOCK_STABLE_CYC(8), .MAX_RETRY(2),
    .IDSEL_DEF(ID_D), .FBDSEL_DEF(FB_D), .ODSEL_DEF(OD_D), .PSDA_DEF(PS_D)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_idsel(cfg_idsel), .cfg_fbdsel(cfg_fbdsel), .cfg_odsel(cfg_odsel), .cfg_psda(cfg_psda),
    .pll_lock(pll_lock), .pll_reset(pll_reset), .pll_idsel(pll_idsel), .pll_fbdsel(pll_fbdsel),
    .pll_odsel(pll_odsel), .pll_psda(pll_psda), .sys_rst_n(sys_rst_n), .locked(locked),
    .fault(fault), .lock_lost(lock_lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic pll_reset, sys_rst_n, locked, fault, cfg_ready, lock_lost;
  } out_t;

  typedef struct {
    logic lock;
    out_t exp;
  } vec_t;

  vec_t vec[64];
  out_t sb[$];
  int   total = 0;
  int   passed = 0;

  function automatic out_t mk(input logic pr, input logic sy, input logic lk,
                              input logic ft, input logic rd, input logic ll);
    out_t o;
    o = '{pll_reset: pr, sys_rst_n: sy, locked: lk, fault: ft, cfg_ready: rd, lock_lost: ll};
    return o;
  endfunction

  task automatic sb_cmp(input string name);
    out_t a, e;
    a = '{pll_reset: pll_reset, sys_rst_n: sys_rst_n, locked: locked, fault: fault,
          cfg_ready: cfg_ready, lock_lost: lock_lost};
    total++;
    if (sb.size() == 0) begin
      $display("FAIL %s: scoreboard empty, got %b", name, a);
      return;
    end
    e = sb.pop_front();
    if (a === e) passed++;
    else $display("FAIL %s: got %b want %b (rst,sys,lck,flt,rdy,lost)", name, a, e);
  endtask

  task automatic chk(input string name, input logic [21:0] act, input logic [21:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hold_reset();
    rst_n = 1'b0; pll_lock = 1'b0; cfg_valid = 1'b0;
    step(2);
  endtask

  // Vector i covers the i-th cycle after rst_n release; outputs sampled mid-cycle.
  task automatic run_table(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      pll_lock = vec[i].lock;
      if (i == 0) rst_n = 1'b1;
      sb.push_back(vec[i].exp);
      @(negedge clk);
      sb_cmp($sformatf("%s[%0d]", name, i));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    cfg_idsel = ID_D; cfg_fbdsel = FB_D; cfg_odsel = OD_D; cfg_psda = PS_D;
    hold_reset();
    sb.push_back(mk(1, 0, 0, 0, 0, 0));
    sb_cmp("reset_state");
    chk("reset_sel", {pll_idsel, pll_fbdsel, pll_odsel, pll_psda}, {ID_D, FB_D, OD_D, PS_D});

    // Bring-up: lock at T0+6, release at T0+16.
    for (int i = 0; i < 20; i++) begin
      vec[i].lock = (i >= 6);
      vec[i].exp  = mk(i < 4, i >= 16, i >= 16, 1'b0, i >= 16, 1'b0);
    end
    run_table(20, "bringup");

    // Reconfig in RUN (cycle 20).
    cfg_fbdsel = 6'h3A; cfg_odsel = 6'h38; cfg_valid = 1'b1;
    sb.push_back(mk(1, 0, 0, 0, 0, 0));
    step(1);
    cfg_valid = 1'b0;
    sb_cmp("reconfig_next");
    chk("reconfig_sel", {pll_fbdsel, pll_odsel}, {6'h3A, 6'h38});
    sb.push_back(mk(0, 0, 0, 0, 0, 0));
    step(11);
    sb_cmp("reconfig_prelock");
    sb.push_back(mk(0, 1, 1, 0, 1, 0));
    step(1);
    sb_cmp("reconfig_relock");

    // Lock loss in RUN (cycle 33): drop at 34, visible at 37.
    step(1);
    pll_lock = 1'b0;
    sb.push_back(mk(0, 1, 1, 0, 1, 0));
    step(2);
    sb_cmp("loss_pre");
    sb.push_back(mk(1, 0, 0, 0, 0, 1));
    step(1);
    sb_cmp("loss_seen");
    pll_lock = 1'b1;
    sb.push_back(mk(0, 0, 0, 0, 0, 1));
    step(11);
    sb_cmp("lost_sticky_stable");
    sb.push_back(mk(0, 1, 1, 0, 1, 1));
    step(1);
    sb_cmp("lost_sticky_run");
    cfg_psda = 4'h9; cfg_valid = 1'b1;
    sb.push_back(mk(1, 0, 0, 0, 0, 0));
    step(1);
    cfg_valid = 1'b0;
    sb_cmp("lost_clear");
    chk("lost_clear_psda", 22'(pll_psda), 22'(4'h9));

    // Handshake and lock drop in the same RUN cycle (62): handshake wins.
    step(10);
    pll_lock = 1'b0;
    sb.push_back(mk(0, 1, 1, 0, 1, 0));
    step(2);
    sb_cmp("race_run");
    cfg_idsel = 6'h2A; cfg_valid = 1'b1;
    sb.push_back(mk(1, 0, 0, 0, 0, 0));
    step(1);
    cfg_valid = 1'b0;
    sb_cmp("race_hs_wins");
    chk("race_idsel", 22'(pll_idsel), 22'(6'h2A));

    // Lock glitch during qualify: release delayed to T0+24.
    cfg_idsel = ID_D;
    hold_reset();
    for (int i = 0; i < 26; i++) begin
      vec[i].lock = (i >= 6) && !(i >= 11 && i <= 13);
      vec[i].exp  = mk(i < 4, i >= 24, i >= 24, 1'b0, i >= 24, 1'b0);
    end
    run_table(26, "glitch");

    // No lock ever: two 4+20 attempts, fault at T0+48.
    hold_reset();
    for (int i = 0; i < 49; i++) begin
      vec[i].lock = 1'b0;
      vec[i].exp  = mk(!((i >= 4 && i <= 23) || (i >= 28 && i <= 47)), 1'b0, 1'b0,
                       i >= 48, i >= 48, 1'b0);
    end
    run_table(49, "nolock");
    cfg_idsel = 6'h15; cfg_valid = 1'b1;
    sb.push_back(mk(1, 0, 0, 0, 0, 0));
    step(1);
    cfg_valid = 1'b0;
    sb_cmp("fault_clear");
    chk("fault_idsel", 22'(pll_idsel), 22'(6'h15));
    sb.push_back(mk(0, 0, 0, 0, 0, 0));
    step(4);
    sb_cmp("restart_wait");

    // Async reset mid-STABLE: outputs return to defaults without a clock edge.
    pll_lock = 1'b1;
    step(6);
    rst_n = 1'b0;
    #1;
    sb.push_back(mk(1, 0, 0, 0, 0, 0));
    sb_cmp("async_reset");
    chk("async_reset_sel", {pll_idsel, pll_fbdsel, pll_odsel, pll_psda}, {ID_D, FB_D, OD_D, PS_D});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
